// File: rtl/apple_iie_keyboard_encoder.sv
// Apple IIe keyboard matrix encoder: column scan, per-scan hit capture, debounce,
// 2-key rollover and auto-repeat, producing a matrix position code and key strobe.
module apple_iie_keyboard_encoder #(
  parameter int unsigned SCAN_DIV       = 16,
  parameter int unsigned DEBOUNCE_SCANS = 32,
  parameter int unsigned REPEAT_DELAY   = 3400,
  parameter int unsigned REPEAT_RATE    = 427
) (
  input  logic       clk_phi_0,
  input  logic       reset_n,
  output logic [9:0] x_n,
  input  logic [7:0] y_n,
  input  logic       shift_n,
  input  logic       ctrl_n,
  output logic [6:0] key_code,
  output logic       key_shift,
  output logic       key_ctrl,
  output logic       kstrb,
  output logic       akd
);
  localparam int unsigned NUM_COLS = 10;
  localparam int unsigned DIV_W    = $clog2(SCAN_DIV);
  localparam int unsigned DEB_W    = $clog2(DEBOUNCE_SCANS + 1);
  localparam int unsigned RPT_W    = 12;

  typedef enum logic [1:0] {IDLE, DEBOUNCE, HELD, REPEAT} state_t;

  state_t           state, state_next;
  logic [DIV_W-1:0] div;
  logic [3:0]       col, col_next;
  logic             sample_c, scan_done_c;

  logic [6:0]       cand, cand_next;
  logic [DEB_W-1:0] deb, deb_next, deb_inc;
  logic [RPT_W-1:0] rpt, rpt_next, rpt_inc;
  logic [6:0]       code_next;
  logic             shift_next, ctrl_next, kstrb_next, akd_next, accept;

  logic             found_any, found_any_c;
  logic [6:0]       first_code, first_code_c;
  logic             locked_seen, locked_seen_c;
  logic             cand_seen, cand_seen_c;
  logic             other_found, other_found_c;
  logic [6:0]       other_code, other_code_c;
  logic [7:0]       hits_c, locked_mask_c, other_hits_c;

  function automatic logic [2:0] lowest_row(input logic [7:0] hits);
    lowest_row = 3'd0;
    for (int r = 7; r >= 0; r--) begin
      if (hits[r]) lowest_row = 3'(r);
    end
  endfunction

  // Scan timing: y_n is only trusted in the last cycle of each column slot
  assign sample_c    = (div == DIV_W'(SCAN_DIV - 1));
  assign scan_done_c = sample_c && (col == 4'(NUM_COLS - 1));
  assign col_next    = sample_c ? ((col == 4'(NUM_COLS - 1)) ? 4'd0 : col + 4'd1) : col;

  // Per-scan hit accumulation, folding in the current sample
  assign hits_c        = ~y_n;
  assign locked_mask_c = (col == key_code[6:3]) ? (8'd1 << key_code[2:0]) : 8'd0;
  assign other_hits_c  = hits_c & ~locked_mask_c;

  assign found_any_c   = found_any | (sample_c & (|hits_c));
  assign first_code_c  = (!found_any && sample_c && (|hits_c)) ? {col, lowest_row(hits_c)}
                                                                : first_code;
  assign locked_seen_c = locked_seen | (sample_c & (|(hits_c & locked_mask_c)));
  assign cand_seen_c   = cand_seen | (sample_c && (col == cand[6:3]) && hits_c[cand[2:0]]);
  assign other_found_c = other_found | (sample_c & (|other_hits_c));
  assign other_code_c  = (!other_found && sample_c && (|other_hits_c))
                           ? {col, lowest_row(other_hits_c)} : other_code;

  assign deb_inc = (deb == DEB_W'(DEBOUNCE_SCANS)) ? deb : deb + DEB_W'(1);
  assign rpt_inc = (&rpt) ? rpt : rpt + RPT_W'(1);

  always_ff @(posedge clk_phi_0 or negedge reset_n) begin
    if (!reset_n) begin
      div         <= '0;
      col         <= '0;
      x_n         <= 10'h3FF;
      found_any   <= 1'b0;
      first_code  <= '0;
      locked_seen <= 1'b0;
      cand_seen   <= 1'b0;
      other_found <= 1'b0;
      other_code  <= '0;
    end else begin
      div <= sample_c ? '0 : div + DIV_W'(1);
      col <= col_next;
      x_n <= ~(10'd1 << col_next);
      if (scan_done_c) begin
        found_any   <= 1'b0;
        first_code  <= '0;
        locked_seen <= 1'b0;
        cand_seen   <= 1'b0;
        other_found <= 1'b0;
        other_code  <= '0;
      end else begin
        found_any   <= found_any_c;
        first_code  <= first_code_c;
        locked_seen <= locked_seen_c;
        cand_seen   <= cand_seen_c;
        other_found <= other_found_c;
        other_code  <= other_code_c;
      end
    end
  end

  always_ff @(posedge clk_phi_0 or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      cand      <= '0;
      deb       <= '0;
      rpt       <= '0;
      key_code  <= '0;
      key_shift <= 1'b0;
      key_ctrl  <= 1'b0;
      kstrb     <= 1'b0;
      akd       <= 1'b0;
    end else begin
      state     <= state_next;
      cand      <= cand_next;
      deb       <= deb_next;
      rpt       <= rpt_next;
      key_code  <= code_next;
      key_shift <= shift_next;
      key_ctrl  <= ctrl_next;
      kstrb     <= kstrb_next;
      akd       <= akd_next;
    end
  end

  // Key FSM, advanced once per full scan; release of the locked key beats rollover
  always_comb begin
    state_next = state;
    cand_next  = cand;
    deb_next   = deb;
    rpt_next   = rpt;
    code_next  = key_code;
    shift_next = key_shift;
    ctrl_next  = key_ctrl;
    kstrb_next = 1'b0;
    akd_next   = akd;
    accept     = 1'b0;
    if (scan_done_c) begin
      unique case (state)
        IDLE: begin
          if (found_any_c) begin
            cand_next  = first_code_c;
            deb_next   = DEB_W'(1);
            state_next = DEBOUNCE;
            accept     = (DEBOUNCE_SCANS == 1);
          end
        end
        DEBOUNCE: begin
          if (cand_seen_c) begin
            deb_next = deb_inc;
            accept   = (deb_inc == DEB_W'(DEBOUNCE_SCANS));
          end else begin
            state_next = IDLE;
            akd_next   = 1'b0;
          end
        end
        HELD, REPEAT: begin
          if (!locked_seen_c) begin
            state_next = IDLE;
            akd_next   = 1'b0;
          end else if (other_found_c) begin
            cand_next  = other_code_c;
            deb_next   = DEB_W'(1);
            state_next = DEBOUNCE;
            accept     = (DEBOUNCE_SCANS == 1);
          end else begin
            rpt_next = rpt_inc;
            if (rpt_inc == ((state == HELD) ? RPT_W'(REPEAT_DELAY) : RPT_W'(REPEAT_RATE))) begin
              kstrb_next = 1'b1;
              rpt_next   = '0;
              state_next = REPEAT;
            end
          end
        end
        default: state_next = IDLE;
      endcase
      if (accept) begin
        code_next  = cand_next;
        shift_next = ~shift_n;
        ctrl_next  = ~ctrl_n;
        kstrb_next = 1'b1;
        akd_next   = 1'b1;
        rpt_next   = '0;
        state_next = HELD;
      end
    end
  end

endmodule
